// File: rtl/promedio_adc.sv
// rtl/promedio_adc.sv - block mean/max/min of 2^LOG2_N ADC samples with valid/ack result handshake
module promedio_adc #(
   parameter int ANCHO  = 12,
   parameter int LOG2_N = 3
) (
   input  logic              Clock_Muestreo,
   input  logic              reset,
   input  logic              enable,
   input  logic              done,
   input  logic [ANCHO-1:0]  Dato,
   input  logic              ack,
   input  logic              clr_overrun,
   output logic              valid,
   output logic [ANCHO-1:0]  Promedio,
   output logic [ANCHO-1:0]  Maximo,
   output logic [ANCHO-1:0]  Minimo,
   output logic [LOG2_N-1:0] conteo,
   output logic              overrun
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACUM   = 2'd1;
   localparam logic [1:0] CIERRE = 2'd2;

   localparam int SUMA_W = ANCHO + LOG2_N;
   localparam logic [LOG2_N-1:0] ULTIMA = '1;

   logic [1:0]        state;
   logic [SUMA_W-1:0] acc;
   logic [ANCHO-1:0]  run_max;
   logic [ANCHO-1:0]  run_min;
   logic [ANCHO-1:0]  max_next;
   logic [ANCHO-1:0]  min_next;
   logic              cierre;

   assign max_next = (Dato > run_max) ? Dato : run_max;
   assign min_next = (Dato < run_min) ? Dato : run_min;
   assign cierre   = (state == CIERRE);

   // Block accumulation; conteo wraps to 0 on the Nth sample, which is when acc holds the full sum.
   always_ff @(posedge Clock_Muestreo or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         acc     <= '0;
         conteo  <= '0;
         run_max <= '0;
         run_min <= '1;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  state   <= ACUM;
                  acc     <= '0;
                  conteo  <= '0;
                  run_max <= '0;
                  run_min <= '1;
               end
            end
            ACUM: begin
               if (!enable) begin
                  state   <= IDLE;
                  acc     <= '0;
                  conteo  <= '0;
                  run_max <= '0;
                  run_min <= '1;
               end else if (done) begin
                  acc     <= acc + SUMA_W'(Dato);
                  conteo  <= conteo + 1'b1;
                  run_max <= max_next;
                  run_min <= min_next;
                  if (conteo == ULTIMA)
                     state <= CIERRE;
               end
            end
            CIERRE: begin
               state <= enable ? ACUM : IDLE;
               // A strobe landing in the closing cycle opens the next block.
               if (enable && done) begin
                  acc     <= SUMA_W'(Dato);
                  conteo  <= LOG2_N'(1);
                  run_max <= Dato;
                  run_min <= Dato;
               end else begin
                  acc     <= '0;
                  conteo  <= '0;
                  run_max <= '0;
                  run_min <= '1;
               end
            end
            default: begin
               state   <= IDLE;
               acc     <= '0;
               conteo  <= '0;
               run_max <= '0;
               run_min <= '1;
            end
         endcase
      end
   end

   // Result registers and handshake; a result arriving in the same cycle as ack stays valid.
   always_ff @(posedge Clock_Muestreo or posedge reset) begin
      if (reset) begin
         valid    <= 1'b0;
         Promedio <= '0;
         Maximo   <= '0;
         Minimo   <= '1;
         overrun  <= 1'b0;
      end else begin
         if (cierre) begin
            Promedio <= ANCHO'(acc >> LOG2_N);
            Maximo   <= run_max;
            Minimo   <= run_min;
            valid    <= 1'b1;
         end else if (ack) begin
            valid <= 1'b0;
         end

         if (cierre && valid && !ack)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;
      end
   end

endmodule
